// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch/data) arbiter in front of a single mem_sys.
// A grant runs IDLE -> ISSUE -> RESP. mem_bus carries the latched request only
// during ISSUE; the completion pulse and read data appear in RESP.
// mem_sys returns data_out during the ISSUE cycle, and that value is registered
// into rdata on the edge into RESP, so it is valid in the same cycle as ack.
// Optional build macro: MEM_ARB_FIXED_PRIO_EN -- a tie always goes to port 0
// instead of alternating round robin.

package mem_arb_pkg;
    typedef struct packed {
        logic [2:0]  mode;
        logic [31:0] address;
        logic [31:0] offset;
        logic [31:0] data;
    } mem_in_bus_t;
endpackage

module mem_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0,
    input  logic                     req1,
    input  logic [2:0]               mode0,
    input  logic [2:0]               mode1,
    input  logic [31:0]              addr0,
    input  logic [31:0]              addr1,
    input  logic [31:0]              off0,
    input  logic [31:0]              off1,
    input  logic [31:0]              wdata0,
    input  logic [31:0]              wdata1,
    output logic                     ack0,
    output logic                     ack1,
    output logic [31:0]              rdata0,
    output logic [31:0]              rdata1,
    output logic                     err0,
    output logic                     err1,
    output mem_arb_pkg::mem_in_bus_t mem_bus,
    input  logic [31:0]              mem_data,
    output logic [CNT_W-1:0]         grant_cnt0,
    output logic [CNT_W-1:0]         grant_cnt1
);

    localparam logic [2:0] MODE_NOP = 3'b100;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t             state_q, state_d;
    logic               rr_q, rr_d;       // port granted last
    logic               gnt_q, gnt_d;     // port owning the current transaction
    logic [2:0]         mode_q, mode_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        off_q, off_d;
    logic [31:0]        data_q, data_d;
    logic               bad_q, bad_d;     // requested mode was illegal
    logic               ack0_q, ack0_d, ack1_q, ack1_d;
    logic               err0_q, err0_d, err1_q, err1_d;
    logic [31:0]        rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [CNT_W-1:0]   cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    logic               gnt_sel;
    logic [2:0]         sel_mode;
    logic               sel_bad;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic returns_data(input logic [2:0] m);
        return (m == 3'b000) || (m == 3'b010) || (m == 3'b111);
    endfunction

    // Pick the winning port for the current IDLE cycle.
    always_comb begin
        if (req0 && req1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            gnt_sel = 1'b0;
`else
            gnt_sel = ~rr_q;
`endif
        end else begin
            gnt_sel = req1;
        end
        sel_mode = gnt_sel ? mode1 : mode0;
        sel_bad  = (sel_mode == 3'b101) || (sel_mode == 3'b110);
    end

    // Next-state and next-output logic for the IDLE/ISSUE/RESP sequence.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        gnt_d    = gnt_q;
        mode_d   = mode_q;
        addr_d   = addr_q;
        off_d    = off_q;
        data_d   = data_q;
        bad_d    = bad_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        err0_d   = 1'b0;
        err1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        cnt0_d   = cnt0_q;
        cnt1_d   = cnt1_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = ISSUE;
                    gnt_d   = gnt_sel;
                    rr_d    = gnt_sel;
                    mode_d  = sel_bad ? MODE_NOP : sel_mode;
                    bad_d   = sel_bad;
                    addr_d  = gnt_sel ? addr1  : addr0;
                    off_d   = gnt_sel ? off1   : off0;
                    data_d  = gnt_sel ? wdata1 : wdata0;
                    if (gnt_sel) cnt1_d = sat_inc(cnt1_q);
                    else         cnt0_d = sat_inc(cnt0_q);
                end
            end
            ISSUE: begin
                state_d = RESP;
                if (gnt_q) begin
                    ack1_d = 1'b1;
                    err1_d = bad_q;
                    if (returns_data(mode_q)) rdata1_d = mem_data;
                end else begin
                    ack0_d = 1'b1;
                    err0_d = bad_q;
                    if (returns_data(mode_q)) rdata0_d = mem_data;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_q     <= 1'b1;
            gnt_q    <= 1'b0;
            mode_q   <= MODE_NOP;
            addr_q   <= '0;
            off_q    <= '0;
            data_q   <= '0;
            bad_q    <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            cnt0_q   <= '0;
            cnt1_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            gnt_q    <= gnt_d;
            mode_q   <= mode_d;
            addr_q   <= addr_d;
            off_q    <= off_d;
            data_q   <= data_d;
            bad_q    <= bad_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            cnt0_q   <= cnt0_d;
            cnt1_q   <= cnt1_d;
        end
    end

    // mem_bus shows the latched request only in ISSUE, a zeroed no-op otherwise.
    always_comb begin
        mem_bus.mode    = MODE_NOP;
        mem_bus.address = '0;
        mem_bus.offset  = '0;
        mem_bus.data    = '0;
        if (state_q == ISSUE) begin
            mem_bus.mode    = mode_q;
            mem_bus.address = addr_q;
            mem_bus.offset  = off_q;
            mem_bus.data    = data_q;
        end
    end

    assign ack0       = ack0_q;
    assign ack1       = ack1_q;
    assign err0       = err0_q;
    assign err1       = err1_q;
    assign rdata0     = rdata0_q;
    assign rdata1     = rdata1_q;
    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written multi-cycle
// sequences, and randomized transactions against a transaction-level model.
// A simple mem_sys stand-in answers mem_bus: 000 load [addr+off], 001 store
// [addr+off], 010 fetch-and-add ([addr] += off, returns new value),
// 111 returns ~[addr+off]; after reset each word holds its own index.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [2:0]  mode0 = 3'b0, mode1 = 3'b0;
    logic [31:0] addr0 = '0, addr1 = '0, off0 = '0, off1 = '0, wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, err0, err1;
    logic [31:0] rdata0, rdata1, mem_data;
    mem_in_bus_t mem_bus, mem_bus_s;
    logic [15:0] gc0, gc1;
    logic        ack0_s, ack1_s, err0_s, err1_s;
    logic [31:0] rdata0_s, rdata1_s;
    logic [1:0]  gc0_s, gc1_s;

    mem_arbiter #(.CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .mode0(mode0), .mode1(mode1),
        .addr0(addr0), .addr1(addr1), .off0(off0), .off1(off1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .mem_bus(mem_bus), .mem_data(mem_data), .grant_cnt0(gc0), .grant_cnt1(gc1));

    // Narrow-counter instance sharing the same stimulus, for saturation.
    mem_arbiter #(.CNT_W(2)) u_dut_s (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .mode0(mode0), .mode1(mode1),
        .addr0(addr0), .addr1(addr1), .off0(off0), .off1(off1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0_s), .ack1(ack1_s), .rdata0(rdata0_s), .rdata1(rdata1_s), .err0(err0_s), .err1(err1_s),
        .mem_bus(mem_bus_s), .mem_data(mem_data), .grant_cnt0(gc0_s), .grant_cnt1(gc1_s));

    always #5 clk = ~clk;

    // ---------------- mem_sys stand-in ----------------
    logic [31:0] smem [256];
    logic [31:0] s_sum;
    logic [7:0]  s_ea, s_a;
    assign s_sum = mem_bus.address + mem_bus.offset;
    assign s_ea  = s_sum[7:0];
    assign s_a   = mem_bus.address[7:0];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) smem[i] <= 32'(i);
        end else if (mem_bus.mode == 3'b001) begin
            smem[s_ea] <= mem_bus.data;
        end else if (mem_bus.mode == 3'b010) begin
            smem[s_a] <= smem[s_a] + mem_bus.offset;
        end
    end

    always_comb begin
        mem_data = 32'h5A5A_5A5A;
        case (mem_bus.mode)
            3'b000:  mem_data = smem[s_ea];
            3'b010:  mem_data = smem[s_a] + mem_bus.offset;
            3'b111:  mem_data = ~smem[s_ea];
            default: mem_data = 32'h5A5A_5A5A;
        endcase
    end

    // ---------------- checking ----------------
    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    endtask

    // ---------------- transaction-level reference model ----------------
    logic [31:0] ref_mem [256];
    bit          m_last;
    int          m_cnt0, m_cnt1;
    logic [31:0] m_rd0, m_rd1;

    task automatic model_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'(i);
        m_last = 1'b1;
        m_cnt0 = 0;
        m_cnt1 = 0;
        m_rd0  = '0;
        m_rd1  = '0;
    endtask

    task automatic model_txn(input bit r0, input bit r1, input logic [2:0] m0, input logic [2:0] m1,
                             input logic [31:0] a0, input logic [31:0] o0, input logic [31:0] d0,
                             input logic [31:0] a1, input logic [31:0] o1, input logic [31:0] d1,
                             output bit g, output mem_in_bus_t eb, output bit eerr);
        logic [2:0]  m;
        logic [31:0] sum, res;
        logic [7:0]  ie, ia;
        g = (r0 && r1) ? (FIXED ? 1'b0 : !m_last) : r1;
        m_last = g;
        m = g ? m1 : m0;
        eerr = (m == 3'b101) || (m == 3'b110);
        eb.mode    = eerr ? 3'b100 : m;
        eb.address = g ? a1 : a0;
        eb.offset  = g ? o1 : o0;
        eb.data    = g ? d1 : d0;
        sum = eb.address + eb.offset;
        ie  = sum[7:0];
        ia  = eb.address[7:0];
        res = '0;
        case (eb.mode)
            3'b000: res = ref_mem[ie];
            3'b001: ref_mem[ie] = eb.data;
            3'b010: begin res = ref_mem[ia] + eb.offset; ref_mem[ia] = res; end
            3'b111: res = ~ref_mem[ie];
            default: ;
        endcase
        if (eb.mode == 3'b000 || eb.mode == 3'b010 || eb.mode == 3'b111) begin
            if (g) m_rd1 = res;
            else   m_rd0 = res;
        end
        if (g) m_cnt1++;
        else   m_cnt0++;
    endtask

    // ---------------- driver / sampler ----------------
    typedef struct {
        mem_in_bus_t bus_idle, bus_iss, bus_resp;
        logic        ack_iss, ack0, ack1, err0, err1, ack_after;
        logic [31:0] rd0, rd1;
        logic [15:0] c0, c1;
        logic [1:0]  c0s;
    } obs_t;

    // Starts at an IDLE cycle (#1 after posedge), returns at the next IDLE cycle.
    task automatic do_txn(input bit r0, input bit r1, input logic [2:0] m0, input logic [2:0] m1,
                          input logic [31:0] a0, input logic [31:0] o0, input logic [31:0] d0,
                          input logic [31:0] a1, input logic [31:0] o1, input logic [31:0] d1,
                          output obs_t ob);
        ob.bus_idle = mem_bus;
        req0 = r0; req1 = r1; mode0 = m0; mode1 = m1;
        addr0 = a0; off0 = o0; wdata0 = d0; addr1 = a1; off1 = o1; wdata1 = d1;
        @(posedge clk); #1;
        ob.bus_iss = mem_bus;
        ob.ack_iss = ack0 | ack1;
        // Requester fields change after the grant; the transaction must not notice.
        req0 = 1'b0; req1 = 1'b0;
        mode0 = 3'($urandom_range(0, 7)); mode1 = 3'($urandom_range(0, 7));
        addr0 = $urandom; addr1 = $urandom; off0 = $urandom; off1 = $urandom;
        wdata0 = $urandom; wdata1 = $urandom;
        @(posedge clk); #1;
        ob.bus_resp = mem_bus;
        ob.ack0 = ack0; ob.ack1 = ack1; ob.err0 = err0; ob.err1 = err1;
        ob.rd0 = rdata0; ob.rd1 = rdata1; ob.c0 = gc0; ob.c1 = gc1; ob.c0s = gc0_s;
        @(posedge clk); #1;
        ob.ack_after = ack0 | ack1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        model_reset();
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          r0, r1;
        logic [2:0]  m0, m1;
        logic [31:0] a0, o0, d0, a1, o1, d1;
        bit          xp;      // port expected to be acked
        logic [2:0]  xmode;   // mode expected on mem_bus in ISSUE
        bit          xerr;
        logic [31:0] xrd;     // granted port's rdata expected with ack
    } vec_t;

    vec_t        tbl [11];
    obs_t        ob;
    string       tg;
    bit          g, eerr, rr0, rr1;
    mem_in_bus_t eb;
    logic [2:0]  rm0, rm1;
    logic [31:0] ra0, ro0, rd0v, ra1, ro1, rd1v;
    int          nack, sat;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 3'b001, 3'b000, 32'h40, 32'h4, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 1'b0, 3'b001, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 3'b000, 3'b000, 32'h40, 32'h4, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 3'b000, 1'b0, 32'hDEADBEEF};
        tbl[2]  = '{1'b0, 1'b1, 3'b000, 3'b010, 32'h0, 32'h0, 32'h0, 32'h8, 32'h8, 32'h0, 1'b1, 3'b010, 1'b0, 32'h10};
        tbl[3]  = '{1'b0, 1'b1, 3'b000, 3'b010, 32'h0, 32'h0, 32'h0, 32'h8, 32'h8, 32'h0, 1'b1, 3'b010, 1'b0, 32'h18};
        tbl[4]  = '{1'b1, 1'b0, 3'b101, 3'b000, 32'h20, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 3'b100, 1'b1, 32'hDEADBEEF};
        tbl[5]  = '{1'b1, 1'b1, 3'b000, 3'b000, 32'h40, 32'h4, 32'h0, 32'h40, 32'h4, 32'h0, FIXED ? 1'b0 : 1'b1, 3'b000, 1'b0, 32'hDEADBEEF};
        tbl[6]  = '{1'b1, 1'b1, 3'b000, 3'b000, 32'h40, 32'h4, 32'h0, 32'h40, 32'h4, 32'h0, 1'b0, 3'b000, 1'b0, 32'hDEADBEEF};
        tbl[7]  = '{1'b1, 1'b1, 3'b000, 3'b000, 32'h40, 32'h4, 32'h0, 32'h40, 32'h4, 32'h0, FIXED ? 1'b0 : 1'b1, 3'b000, 1'b0, 32'hDEADBEEF};
        tbl[8]  = '{1'b1, 1'b1, 3'b110, 3'b110, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 3'b100, 1'b1, 32'hDEADBEEF};
        tbl[9]  = '{1'b0, 1'b1, 3'b000, 3'b111, 32'h0, 32'h0, 32'h0, 32'h10, 32'h0, 32'h0, 1'b1, 3'b111, 1'b0, 32'hFFFFFFEF};
        tbl[10] = '{1'b1, 1'b0, 3'b011, 3'b000, 32'h30, 32'h0, 32'h1234, 32'h0, 32'h0, 32'h0, 1'b0, 3'b011, 1'b0, 32'hDEADBEEF};

        // Reset state
        do_reset();
        chk("rst_acks", 32'({ack1, ack0}), 32'h0);
        chk("rst_errs", 32'({err1, err0}), 32'h0);
        chk("rst_rdata0", rdata0, 32'h0);
        chk("rst_rdata1", rdata1, 32'h0);
        chk("rst_cnts", {gc1, gc0}, 32'h0);
        chk("rst_bus_mode", 32'(mem_bus.mode), 32'h4);
        chk("rst_bus_fields", mem_bus.address | mem_bus.offset | mem_bus.data, 32'h0);

        // Directed table, applied back to back from reset
        for (int i = 0; i < 11; i++) begin
            do_txn(tbl[i].r0, tbl[i].r1, tbl[i].m0, tbl[i].m1, tbl[i].a0, tbl[i].o0, tbl[i].d0,
                   tbl[i].a1, tbl[i].o1, tbl[i].d1, ob);
            tg = $sformatf("vec%0d", i);
            chk({tg, "_idle_mode"}, 32'(ob.bus_idle.mode), 32'h4);
            chk({tg, "_ack_in_issue"}, 32'(ob.ack_iss), 32'h0);
            chk({tg, "_bus_mode"}, 32'(ob.bus_iss.mode), 32'(tbl[i].xmode));
            chk({tg, "_bus_addr"}, ob.bus_iss.address, tbl[i].xp ? tbl[i].a1 : tbl[i].a0);
            chk({tg, "_acks"}, 32'({ob.ack1, ob.ack0}), tbl[i].xp ? 32'h2 : 32'h1);
            chk({tg, "_err"}, 32'({ob.err1, ob.err0}), tbl[i].xerr ? (tbl[i].xp ? 32'h2 : 32'h1) : 32'h0);
            chk({tg, "_rdata"}, tbl[i].xp ? ob.rd1 : ob.rd0, tbl[i].xrd);
            chk({tg, "_resp_mode"}, 32'(ob.bus_resp.mode), 32'h4);
            chk({tg, "_ack_after"}, 32'(ob.ack_after), 32'h0);
        end

        // Reset asserted in the ISSUE cycle
        req0 = 1'b1; req1 = 1'b0; mode0 = 3'b000; addr0 = 32'h40; off0 = 32'h4; wdata0 = 32'h0;
        @(posedge clk); #1;
        chk("rstmid_issue_mode", 32'(mem_bus.mode), 32'h0);
        reset = 1'b1;
        #1;
        chk("rstmid_acks", 32'({ack1, ack0}), 32'h0);
        chk("rstmid_errs", 32'({err1, err0}), 32'h0);
        chk("rstmid_rdata0", rdata0, 32'h0);
        chk("rstmid_rdata1", rdata1, 32'h0);
        chk("rstmid_cnts", {gc1, gc0}, 32'h0);
        chk("rstmid_bus_mode", 32'(mem_bus.mode), 32'h4);
        chk("rstmid_bus_addr", mem_bus.address, 32'h0);
        req0 = 1'b0;
        model_reset();
        @(posedge clk); #1;
        chk("rstmid_noack", 32'({ack1, ack0}), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        do_txn(1'b1, 1'b0, 3'b000, 3'b000, 32'h40, 32'h4, 32'h0, 32'h0, 32'h0, 32'h0, ob);
        chk("rstmid_fresh_noack_t1", 32'(ob.ack_iss), 32'h0);
        chk("rstmid_fresh_ack_t2", 32'({ob.ack1, ob.ack0}), 32'h1);
        chk("rstmid_fresh_rdata", ob.rd0, 32'h44);

        // Counter saturation with CNT_W = 2
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            do_txn(1'b1, 1'b0, 3'b100, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, ob);
            chk($sformatf("sat_cnt0_narrow_%0d", k), 32'(ob.c0s), (k > 3) ? 32'd3 : 32'(k));
            chk($sformatf("sat_cnt0_wide_%0d", k), 32'(ob.c0), 32'(k));
        end

        // Both ports requesting continuously from reset
        reset = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b1; req1 = 1'b1; mode0 = 3'b000; mode1 = 3'b000;
        addr0 = 32'h40; off0 = 32'h4; addr1 = 32'h40; off1 = 32'h4;
        @(negedge clk);
        reset = 1'b0;
        nack = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (ack0 || ack1) begin
                chk($sformatf("tie_ack%0d", nack), 32'({ack1, ack0}),
                    (FIXED || (nack % 2 == 0)) ? 32'h1 : 32'h2);
                nack++;
            end
        end
        chk("tie_ack_count", 32'(nack), 32'd5);

        // Randomized transactions against the reference model
        do_reset();
        for (int t = 0; t < 150; t++) begin
            rr0 = ($urandom_range(0, 3) != 0);
            rr1 = ($urandom_range(0, 3) != 0);
            rm0 = 3'($urandom_range(0, 7)); rm1 = 3'($urandom_range(0, 7));
            ra0 = $urandom_range(0, 255); ro0 = $urandom_range(0, 15); rd0v = $urandom;
            ra1 = $urandom_range(0, 255); ro1 = $urandom_range(0, 15); rd1v = $urandom;
            tg = $sformatf("rnd%0d", t);
            if (!rr0 && !rr1) begin
                req0 = 1'b0; req1 = 1'b0;
                @(posedge clk); #1;
                chk({tg, "_idle_acks"}, 32'({ack1, ack0}), 32'h0);
                chk({tg, "_idle_mode"}, 32'(mem_bus.mode), 32'h4);
            end else begin
                model_txn(rr0, rr1, rm0, rm1, ra0, ro0, rd0v, ra1, ro1, rd1v, g, eb, eerr);
                do_txn(rr0, rr1, rm0, rm1, ra0, ro0, rd0v, ra1, ro1, rd1v, ob);
                chk({tg, "_bus_mode"}, 32'(ob.bus_iss.mode), 32'(eb.mode));
                chk({tg, "_bus_addr"}, ob.bus_iss.address, eb.address);
                chk({tg, "_bus_off"}, ob.bus_iss.offset, eb.offset);
                chk({tg, "_bus_data"}, ob.bus_iss.data, eb.data);
                chk({tg, "_ack_in_issue"}, 32'(ob.ack_iss), 32'h0);
                chk({tg, "_acks"}, 32'({ob.ack1, ob.ack0}), g ? 32'h2 : 32'h1);
                chk({tg, "_errs"}, 32'({ob.err1, ob.err0}), eerr ? (g ? 32'h2 : 32'h1) : 32'h0);
                chk({tg, "_rdata0"}, ob.rd0, m_rd0);
                chk({tg, "_rdata1"}, ob.rd1, m_rd1);
                chk({tg, "_cnt0"}, 32'(ob.c0), 32'(m_cnt0));
                chk({tg, "_cnt1"}, 32'(ob.c1), 32'(m_cnt1));
                sat = (m_cnt0 > 3) ? 3 : m_cnt0;
                chk({tg, "_cnt0_narrow"}, 32'(ob.c0s), 32'(sat));
                chk({tg, "_ack_after"}, 32'(ob.ack_after), 32'h0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of each per-port saturating grant counter.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports req0/req1  input  1  request from port 0 (fetch) / port 1 (data).
REQ-005 SHALL have ports mode0/mode1  input  3  requested mem_sys mode per port.
REQ-006 SHALL have ports addr0/addr1, off0/off1, wdata0/wdata1  input  32  address, offset, store data per port.
REQ-007 SHALL have ports ack0/ack1  output  1  one-cycle completion pulse per port.
REQ-008 SHALL have ports rdata0/rdata1  output  32  registered read result per port.
REQ-009 SHALL have ports err0/err1  output  1  pulses with ack when the requested mode was illegal.
REQ-010 SHALL have port mem_bus  output  mem_in_bus_t  address/offset/data/mode driven to mem_sys.
REQ-011 SHALL have port mem_data  input  32  mem_sys data_out.
REQ-012 SHALL have ports grant_cnt0/grant_cnt1  output  CNT_W  grants issued per port.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, RESP; IDLE->ISSUE when any req high, ISSUE->RESP unconditionally, RESP->IDLE unconditionally.
REQ-014 SHALL, in IDLE with both req high, grant the port not granted last (round robin); a single requester is granted directly.
REQ-015 SHALL latch the granted port's mode/address/offset/data on the IDLE->ISSUE edge; later requester changes do not affect the transaction.
REQ-016 SHALL drive mem_bus with the latched fields for exactly the ISSUE cycle, and mode 3'b100 with address/offset/data zero in IDLE and RESP.
REQ-017 SHALL translate requested modes 3'b101 and 3'b110 to 3'b100 on mem_bus and assert the port's err with ack.
REQ-018 SHALL, in RESP, pulse the granted port's ack for one cycle; the other port's ack stays low.
REQ-019 SHALL, in RESP, copy mem_data into the granted port's rdata for modes 000, 010, 111; rdata holds for all other modes.
REQ-020 SHALL give latency: req sampled high in IDLE cycle T -> ISSUE in T+1 -> ack in T+2; throughput one transaction per 3 cycles.
REQ-021 SHALL require requesters to hold req and fields stable until ack; req sampled in the RESP cycle is ignored, sampled again in IDLE.
REQ-022 SHALL increment the granted port's grant_cnt on IDLE->ISSUE, saturating at all-ones (no wrap).
REQ-023 SHALL update the round-robin pointer to the granted port on every grant.

Reset
REQ-024 SHALL on reset asynchronously force state IDLE, mem_bus mode 3'b100 with other fields zero, ack0/ack1/err0/err1 low, rdata0/rdata1 zero, grant counters zero, round-robin pointer = port 1 (so port 0 wins first tie).
REQ-025 SHALL, on reset asserted mid-transaction (ISSUE or RESP), abandon the transaction with no ack; mem_sys shares the same reset.

Configuration
REQ-026 SHALL, with MEM_ARB_FIXED_PRIO_EN defined, always grant port 0 on a tie (pointer unused); without it, round robin per REQ-014.

Verification
REQ-027 SHALL cover: req0 mode 001 addr 0x40 off 4 wdata 0xDEADBEEF, then req0 mode 000 same addr/off -> mem_bus mode 001 in ISSUE, second ack0 with rdata0 = 0xDEADBEEF, ack latency 2 cycles each.
REQ-028 SHALL cover: req0 and req1 both high continuously from reset, mode 000 -> grants alternate 0,1,0,1; with MEM_ARB_FIXED_PRIO_EN only port 0 acked.
REQ-029 SHALL cover: req1 mode 010 off 8 twice after reset -> rdata1 = 0x10 then 0x18.
REQ-030 SHALL cover: req0 mode 101 -> mem_bus mode 100 in ISSUE, ack0 and err0 pulse together, rdata0 unchanged.
REQ-031 SHALL cover: reset asserted in ISSUE cycle -> no ack, all outputs at reset values the same cycle, fresh req0 acked 2 cycles after reset release.
REQ-032 SHALL cover: CNT_W = 2, 5 grants to port 0 -> grant_cnt0 = 3 after third grant and stays 3.
